alu_result_sel_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-input ALU result selector (and/or/add/slt).
- Selects one of NUM_IN result words of WIDTH bits by a binary select code.
- Two registered mux-tree stages with valid/ready flow control, so the datapath result bus sits between the EX result producers and the EX/MEM boundary.
- Downstream stalls apply back-pressure without losing or duplicating beats.

---
 rtl/alu_result_sel_pipe.sv | 132 +++++++++++++
 tb/tb_alu_result_sel_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sel_pipe.sv
// Two-stage pipelined result selector: picks one of NUM_IN words by binary select.
// Optional range-error reporting is enabled with the ALU_SEL_RANGE_CHECK_EN macro.
module alu_result_sel_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef ALU_SEL_RANGE_CHECK_EN
   ,
   output logic                    out_sel_err,
   output logic                    sel_err_sticky
`endif
);

   localparam int unsigned GROUPS = (NUM_IN + 3) / 4;
   // Group index width; kept at least 1 bit so narrow selects still elaborate.
   localparam int unsigned HI_W   = (SEL_W > 2) ? SEL_W - 2 : 1;
   localparam int unsigned EXT_W  = HI_W + 2;
   localparam int unsigned PAD_W  = GROUPS * 4 * WIDTH;

   if ((2 ** SEL_W) < NUM_IN) begin : g_sel_w_check
      $error("alu_result_sel_pipe: SEL_W too narrow for NUM_IN");
   end

   logic [PAD_W-1:0] in_pad;
   logic [EXT_W-1:0] sel_ext;
   logic [1:0]       sel_lo;
   logic [HI_W-1:0]  sel_hi;
   logic             sel_oor;
   logic [WIDTH-1:0] part_d [GROUPS];

   logic             s1_valid;
   logic [WIDTH-1:0] s1_part [GROUPS];
   logic [HI_W-1:0]  s1_hi;
   logic             s1_oor;
   logic             s2_valid;
   logic [WIDTH-1:0] s2_word;

   logic             s1_load;
   logic             s2_load;
   logic             in_fire;

   // Missing candidates in the last group read as zero.
   assign in_pad  = PAD_W'(in_data);
   assign sel_ext = EXT_W'(in_sel);
   assign sel_lo  = sel_ext[1:0];
   assign sel_hi  = sel_ext[EXT_W-1:2];
   assign sel_oor = (32'(in_sel) >= NUM_IN);

   assign s2_load   = ~s2_valid | out_ready;
   assign s1_load   = ~s1_valid | s2_load;
   assign in_ready  = s1_load;
   assign in_fire   = in_valid & in_ready;
   assign out_valid = s2_valid;

   always_comb begin
      for (int g = 0; g < int'(GROUPS); g++) begin
         part_d[g] = in_pad[(4 * g + int'(sel_lo)) * WIDTH +: WIDTH];
      end
   end

   always_comb begin
      s2_word = '0;
      for (int g = 0; g < int'(GROUPS); g++) begin
         if (s1_hi == HI_W'(g)) begin
            s2_word = s1_part[g];
         end
      end
      if (s1_oor) begin
         s2_word = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_hi    <= '0;
         s1_oor   <= 1'b0;
         for (int g = 0; g < int'(GROUPS); g++) begin
            s1_part[g] <= '0;
         end
      end else if (s1_load) begin
         // Valid clears when the beat moves on with nothing behind it; data holds.
         s1_valid <= in_valid;
         if (in_fire) begin
            s1_hi  <= sel_hi;
            s1_oor <= sel_oor;
            for (int g = 0; g < int'(GROUPS); g++) begin
               s1_part[g] <= part_d[g];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= s2_word;
         end
      end
   end

`ifdef ALU_SEL_RANGE_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sel_err    <= 1'b0;
         sel_err_sticky <= 1'b0;
      end else begin
         if (s2_load && s1_valid) begin
            out_sel_err <= s1_oor;
         end
         if (out_valid && out_ready && out_sel_err) begin
            sel_err_sticky <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench for alu_result_sel_pipe: default, NUM_IN=5 and 16-input builds.
// Checks ALU_SEL_RANGE_CHECK_EN outputs when that macro is defined.
module tb_alu_result_sel_pipe;

   logic clk;
   logic rst_n;

   logic [127:0] d_in_data;
   logic [1:0]   d_in_sel;
   logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [31:0]  d_out_data;

   logic [159:0] f_in_data;
   logic [2:0]   f_in_sel;
   logic         f_in_valid, f_in_ready, f_out_valid, f_out_ready;
   logic [31:0]  f_out_data;

   logic [127:0] w_in_data;
   logic [3:0]   w_in_sel;
   logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic [7:0]   w_out_data;

`ifdef ALU_SEL_RANGE_CHECK_EN
   logic d_sel_err, d_sticky, f_sel_err, f_sticky, w_sel_err, w_sticky;
`endif

   int tests = 0;
   int fails = 0;

   alu_result_sel_pipe u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (d_in_data),
      .in_sel         (d_in_sel),
      .in_valid       (d_in_valid),
      .in_ready       (d_in_ready),
      .out_data       (d_out_data),
      .out_valid      (d_out_valid),
      .out_ready      (d_out_ready)
`ifdef ALU_SEL_RANGE_CHECK_EN
      ,
      .out_sel_err    (d_sel_err),
      .sel_err_sticky (d_sticky)
`endif
   );

   alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) u_dut5 (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (f_in_data),
      .in_sel         (f_in_sel),
      .in_valid       (f_in_valid),
      .in_ready       (f_in_ready),
      .out_data       (f_out_data),
      .out_valid      (f_out_valid),
      .out_ready      (f_out_ready)
`ifdef ALU_SEL_RANGE_CHECK_EN
      ,
      .out_sel_err    (f_sel_err),
      .sel_err_sticky (f_sticky)
`endif
   );

   alu_result_sel_pipe #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) u_dut16 (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (w_in_data),
      .in_sel         (w_in_sel),
      .in_valid       (w_in_valid),
      .in_ready       (w_in_ready),
      .out_data       (w_out_data),
      .out_valid      (w_out_valid),
      .out_ready      (w_out_ready)
`ifdef ALU_SEL_RANGE_CHECK_EN
      ,
      .out_sel_err    (w_sel_err),
      .sel_err_sticky (w_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if (d_out_valid !== 1'b0 || d_out_data !== 32'h0 || d_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_default: valid=%b data=%h ready=%b, required 0 0 1",
                  d_out_valid, d_out_data, d_in_ready);
      end
      tests++;
      if (f_out_valid !== 1'b0 || f_out_data !== 32'h0 || f_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_n5: valid=%b data=%h ready=%b, required 0 0 1",
                  f_out_valid, f_out_data, f_in_ready);
      end
      tests++;
      if (w_out_valid !== 1'b0 || w_out_data !== 8'h0 || w_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_n16: valid=%b data=%h ready=%b, required 0 0 1",
                  w_out_valid, w_out_data, w_in_ready);
      end
`ifdef ALU_SEL_RANGE_CHECK_EN
      tests++;
      if (f_sel_err !== 1'b0 || f_sticky !== 1'b0) begin
         fails++;
         $display("FAIL reset_err: err=%b sticky=%b, required 0 0", f_sel_err, f_sticky);
      end
`endif
   endtask

   task automatic test_alu_map;
      logic [31:0] exp [4];
      exp = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000005, 32'h00000001};
      d_out_ready = 1'b1;
      d_in_data   = {32'h1, 32'h5, 32'hF0F0F0F0, 32'h0F0F0F0F};
      for (int c = 0; c < 6; c++) begin
         d_in_valid = (c < 4);
         d_in_sel   = 2'(c);
         #1;
         tests++;
         if (c >= 2) begin
            if (d_out_valid !== 1'b1 || d_out_data !== exp[c-2]) begin
               fails++;
               $display("FAIL alu_map cycle %0d: valid=%b data=%h, required 1 %h",
                        c, d_out_valid, d_out_data, exp[c-2]);
            end
         end else if (d_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL alu_map_latency cycle %0d: valid=%b, required 0", c, d_out_valid);
         end
         next_cycle;
      end
      d_in_valid = 1'b0;
      #1;
      tests++;
      if (d_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL alu_map_drain: valid=%b, required 0", d_out_valid);
      end
      next_cycle;
   endtask

   task automatic test_back_to_back;
      int bi = 0;
      int n_out = 0;
      logic exp_rdy;
      for (int c = 0; c < 16; c++) begin
         d_in_valid  = (bi < 6);
         d_in_data   = {96'h0, 32'h100 + 32'(bi)};
         d_in_sel    = 2'd0;
         d_out_ready = !(c >= 3 && c <= 6);
         #1;
         if (c <= 9) begin
            exp_rdy = !(c >= 3 && c <= 6);
            tests++;
            if (d_in_ready !== exp_rdy) begin
               fails++;
               $display("FAIL backpressure_ready cycle %0d: in_ready=%b, required %b",
                        c, d_in_ready, exp_rdy);
            end
         end
         if (d_out_valid === 1'b1) begin
            tests++;
            if (n_out >= 6 || d_out_data !== 32'h100 + 32'(n_out)) begin
               fails++;
               $display("FAIL backpressure_data cycle %0d: data=%h, required %h",
                        c, d_out_data, 32'h100 + 32'(n_out));
            end
            if (d_out_ready) n_out++;
         end
         if (d_in_valid && d_in_ready) bi++;
         next_cycle;
      end
      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      tests++;
      if (n_out != 6 || bi != 6) begin
         fails++;
         $display("FAIL backpressure_count: out=%0d in=%0d, required 6 6", n_out, bi);
      end
   endtask

   task automatic test_range_n5;
      logic [2:0]  sels [3];
      logic [31:0] exp  [3];
      logic        experr [3];
      sels   = '{3'd4, 3'd6, 3'd0};
      exp    = '{32'hDEADBEEF, 32'h0, 32'h11};
      experr = '{1'b0, 1'b1, 1'b0};
      f_out_ready = 1'b1;
      f_in_data   = {32'hDEADBEEF, 32'h44, 32'h33, 32'h22, 32'h11};
      for (int c = 0; c < 6; c++) begin
         f_in_valid = (c < 3);
         f_in_sel   = (c < 3) ? sels[c] : 3'd7;
         #1;
         if (c >= 2 && c <= 4) begin
            tests++;
            if (f_out_valid !== 1'b1 || f_out_data !== exp[c-2]) begin
               fails++;
               $display("FAIL range_n5 cycle %0d: valid=%b data=%h, required 1 %h",
                        c, f_out_valid, f_out_data, exp[c-2]);
            end
`ifdef ALU_SEL_RANGE_CHECK_EN
            tests++;
            if (f_sel_err !== experr[c-2]) begin
               fails++;
               $display("FAIL range_err cycle %0d: out_sel_err=%b, required %b",
                        c, f_sel_err, experr[c-2]);
            end
`endif
         end
`ifdef ALU_SEL_RANGE_CHECK_EN
         if (c == 2 || c >= 4) begin
            tests++;
            if (f_sticky !== (c >= 4)) begin
               fails++;
               $display("FAIL range_sticky cycle %0d: sticky=%b, required %b",
                        c, f_sticky, (c >= 4));
            end
         end
`endif
         next_cycle;
      end
      f_in_valid = 1'b0;
   endtask

   task automatic test_wide_n16;
      w_out_ready = 1'b1;
      for (int k = 0; k < 16; k++) w_in_data[k*8 +: 8] = 8'(k + 16);
      for (int c = 0; c < 18; c++) begin
         w_in_valid = (c < 16);
         w_in_sel   = 4'(c);
         #1;
         tests++;
         if (c >= 2) begin
            if (w_out_valid !== 1'b1 || w_out_data !== 8'(c - 2 + 16)) begin
               fails++;
               $display("FAIL wide_n16 cycle %0d: valid=%b data=%h, required 1 %h",
                        c, w_out_valid, w_out_data, 8'(c - 2 + 16));
            end
         end else if (w_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL wide_n16_latency cycle %0d: valid=%b, required 0", c, w_out_valid);
         end
         next_cycle;
      end
      w_in_valid = 1'b0;
      next_cycle;
   endtask

   task automatic test_reset_mid;
      d_out_ready = 1'b0;
      d_in_sel    = 2'd0;
      for (int c = 0; c < 2; c++) begin
         d_in_valid = 1'b1;
         d_in_data  = {96'h0, 32'hA0 + 32'(c)};
         next_cycle;
      end
      d_in_valid = 1'b0;
      #1;
      tests++;
      if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_out_data !== 32'hA0) begin
         fails++;
         $display("FAIL reset_mid_full: ready=%b valid=%b data=%h, required 0 1 000000a0",
                  d_in_ready, d_out_valid, d_out_data);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (d_out_valid !== 1'b0 || d_out_data !== 32'h0 || d_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_async: valid=%b data=%h ready=%b, required 0 0 1",
                  d_out_valid, d_out_data, d_in_ready);
      end
`ifdef ALU_SEL_RANGE_CHECK_EN
      tests++;
      if (f_sticky !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_sticky: sticky=%b, required 0", f_sticky);
      end
`endif
      next_cycle;
      rst_n       = 1'b1;
      d_out_ready = 1'b1;
      d_in_valid  = 1'b1;
      d_in_sel    = 2'd2;
      d_in_data   = {32'h0, 32'h7, 64'h0};
      next_cycle;
      d_in_valid = 1'b0;
      #1;
      tests++;
      if (d_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_early: valid=%b, required 0", d_out_valid);
      end
      next_cycle;
      tests++;
      if (d_out_valid !== 1'b1 || d_out_data !== 32'h7) begin
         fails++;
         $display("FAIL reset_mid_beat: valid=%b data=%h, required 1 00000007",
                  d_out_valid, d_out_data);
      end
      next_cycle;
   endtask

   task automatic test_full_shift;
      d_in_sel = 2'd0;
      for (int c = 0; c < 9; c++) begin
         d_out_ready = (c >= 2);
         d_in_valid  = (c < 6);
         d_in_data   = {96'h0, 32'hC0 + 32'(c)};
         #1;
         if (c < 6) begin
            tests++;
            if (d_in_ready !== 1'b1) begin
               fails++;
               $display("FAIL full_shift_ready cycle %0d: in_ready=%b, required 1",
                        c, d_in_ready);
            end
         end
         if (c >= 2 && c < 8) begin
            tests++;
            if (d_out_valid !== 1'b1 || d_out_data !== 32'hC0 + 32'(c - 2)) begin
               fails++;
               $display("FAIL full_shift_out cycle %0d: valid=%b data=%h, required 1 %h",
                        c, d_out_valid, d_out_data, 32'hC0 + 32'(c - 2));
            end
         end else if (c == 8) begin
            tests++;
            if (d_out_valid !== 1'b0) begin
               fails++;
               $display("FAIL full_shift_drain: valid=%b, required 0", d_out_valid);
            end
         end
         next_cycle;
      end
      d_in_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      d_in_data   = '0;
      d_in_sel    = '0;
      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      f_in_data   = '0;
      f_in_sel    = '0;
      f_in_valid  = 1'b0;
      f_out_ready = 1'b1;
      w_in_data   = '0;
      w_in_sel    = '0;
      w_in_valid  = 1'b0;
      w_out_ready = 1'b1;
      next_cycle;
      next_cycle;
      test_reset;
      rst_n = 1'b1;
      next_cycle;
      test_alu_map;
      test_back_to_back;
      next_cycle;
      next_cycle;
      test_range_n5;
      test_wide_n16;
      test_reset_mid;
      test_full_shift;
      next_cycle;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
